// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter
//   Round-robin arbiter for one router output port. Each input's next-hop
//   address is decoded against PORT_ID. One requester is granted per cycle
//   from a rotating pointer, and the grant is held from head to tail of a
//   packet. Downstream buffer credits are tracked by a local counter.
//
// Ports
//   clk              clock
//   reset            synchronous, active-low reset
//   req_valid_i      [NUM_IN]         flit present at input i
//   req_addr_i       [NUM_IN*ADDR_W]  next-hop address, input i at [i*ADDR_W +: ADDR_W]
//   req_tail_i       [NUM_IN]         flit at input i is a tail (single-flit packet: 1)
//   credit_return_i  1                downstream freed one buffer slot
//   grant_o          [NUM_IN]         one-hot grant, combinational
//   grant_idx_o      [IDX_W]          index of granted input, 0 when no grant
//   grant_valid_o    1                any grant this cycle
//   credit_cnt_o     [CNT_W]          current credit count
//   locked_o         1                arbiter holds a packet lock
//   credit_ovf_o     1                credit returned while already full (1-cycle pulse)
module rr_port_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int ADDR_W  = 3,
  parameter int PORT_ID = 1,
  parameter int CREDITS = 4,
  parameter int IDX_W   = $clog2(NUM_IN),
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req_valid_i,
  input  logic [NUM_IN*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_IN-1:0]        req_tail_i,
  input  logic                     credit_return_i,
  output logic [NUM_IN-1:0]        grant_o,
  output logic [IDX_W-1:0]         grant_idx_o,
  output logic                     grant_valid_o,
  output logic [CNT_W-1:0]         credit_cnt_o,
  output logic                     locked_o,
  output logic                     credit_ovf_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  owner, owner_nxt;
  logic [CNT_W-1:0]  credit_cnt;
  logic              credit_ovf;
  logic [NUM_IN-1:0] req;
  logic              can_send;
  logic              rr_found;
  logic [IDX_W-1:0]  rr_sel;

  // Increment with wrap at NUM_IN-1, so non-power-of-two port counts work.
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_IN - 1)) ? '0 : v + 1'b1;
  endfunction

  // Request qualification: valid, addressed to this port, and never a U-turn.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      req[i] = req_valid_i[i]
               && (req_addr_i[i*ADDR_W +: ADDR_W] == ADDR_W'(PORT_ID))
               && (i != PORT_ID);
    end
  end

  assign can_send = (credit_cnt != '0);

  // Scan ptr, ptr+1, ... modulo NUM_IN; the first requester found wins.
  always_comb begin
    int cand;
    rr_found = 1'b0;
    rr_sel   = '0;
    cand     = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_sel   = IDX_W'(cand);
      end
    end
  end

  // Next-state and grant logic. While reset is low every combinational
  // output stays at its default of zero.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    grant_o     = '0;
    grant_idx_o = '0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (rr_found && can_send) begin
            grant_o[rr_sel] = 1'b1;
            grant_idx_o     = rr_sel;
            if (req_tail_i[rr_sel]) begin
              ptr_nxt = inc_wrap(rr_sel);
            end else begin
              state_nxt = LOCKED;
              owner_nxt = rr_sel;
            end
          end
        end
        LOCKED: begin
          // Only the owner may proceed; a bubble or lack of credit just waits.
          if (req[owner] && can_send) begin
            grant_o[owner] = 1'b1;
            grant_idx_o    = owner;
            if (req_tail_i[owner]) begin
              state_nxt = IDLE;
              ptr_nxt   = inc_wrap(owner);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign grant_valid_o = |grant_o;
  assign locked_o      = reset && (state == LOCKED);
  assign credit_cnt_o  = credit_cnt;
  assign credit_ovf_o  = credit_ovf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      credit_cnt <= CNT_W'(CREDITS);
      credit_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      // A grant needs a nonzero count, so the decrement never underflows.
      // A return at full count saturates and raises the overflow pulse.
      unique case ({grant_valid_o, credit_return_i})
        2'b10:   credit_cnt <= credit_cnt - CNT_W'(1);
        2'b01:   if (credit_cnt != CNT_W'(CREDITS)) credit_cnt <= credit_cnt + CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
      credit_ovf <= credit_return_i && !grant_valid_o
                    && (credit_cnt == CNT_W'(CREDITS));
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Testbench for rr_port_arbiter (NUM_IN=5, ADDR_W=3, PORT_ID=1, CREDITS=4).
// A driver applies one directed vector per cycle shortly after the rising
// edge and queues the hand-computed expected outputs; a monitor pops one
// expectation per cycle at the falling edge and compares it.
module tb_rr_port_arbiter;

  localparam int NUM_IN  = 5;
  localparam int ADDR_W  = 3;
  localparam int PORT_ID = 1;
  localparam int CREDITS = 4;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_IN-1:0]        req_valid;
  logic [NUM_IN*ADDR_W-1:0] req_addr;
  logic [NUM_IN-1:0]        req_tail;
  logic                     credit_return;
  logic [NUM_IN-1:0]        grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;
  logic [CNT_W-1:0]         credit_cnt;
  logic                     locked;
  logic                     credit_ovf;

  typedef struct {
    int              cyc;
    logic            gv;
    logic [IDX_W-1:0] idx;
    logic            lk;
    logic [CNT_W-1:0] cnt;
    logic            ovf;
    logic            chk_regs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  rr_port_arbiter #(
    .NUM_IN (NUM_IN),
    .ADDR_W (ADDR_W),
    .PORT_ID(PORT_ID),
    .CREDITS(CREDITS),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .req_tail_i     (req_tail),
    .credit_return_i(credit_return),
    .grant_o        (grant),
    .grant_idx_o    (grant_idx),
    .grant_valid_o  (grant_valid),
    .credit_cnt_o   (credit_cnt),
    .locked_o       (locked),
    .credit_ovf_o   (credit_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [NUM_IN-1:0] onehot;
      e = exp_q.pop_front();
      onehot = e.gv ? (NUM_IN'(1) << e.idx) : '0;
      check("grant",       e.cyc, 32'(grant),       32'(onehot));
      check("grant_idx",   e.cyc, 32'(grant_idx),   32'(e.gv ? e.idx : '0));
      check("grant_valid", e.cyc, 32'(grant_valid), 32'(e.gv));
      check("locked",      e.cyc, 32'(locked),      32'(e.lk));
      if (e.chk_regs) begin
        check("credit_cnt", e.cyc, 32'(credit_cnt), 32'(e.cnt));
        check("credit_ovf", e.cyc, 32'(credit_ovf), 32'(e.ovf));
      end
    end
  end

  // Driver: a[i]=1 addresses input i to this port (1), otherwise to port 5.
  task automatic cyc(input logic r, input logic [NUM_IN-1:0] v,
                     input logic [NUM_IN-1:0] t, input logic [NUM_IN-1:0] a,
                     input logic ret, input logic egv, input int eidx,
                     input logic elk, input int ecnt, input logic eovf,
                     input logic chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = r;
    req_valid     = v;
    req_tail      = t;
    credit_return = ret;
    for (int i = 0; i < NUM_IN; i++)
      req_addr[i*ADDR_W +: ADDR_W] = a[i] ? ADDR_W'(PORT_ID) : ADDR_W'(5);
    e.cyc = cyc_no; e.gv = egv; e.idx = IDX_W'(eidx); e.lk = elk;
    e.cnt = CNT_W'(ecnt); e.ovf = eovf; e.chk_regs = chk;
    exp_q.push_back(e);
    cyc_no++;
  endtask

  localparam logic [NUM_IN-1:0] A = 5'b11111;

  initial begin
    reset = 1'b0; req_valid = '0; req_tail = '0; req_addr = '0; credit_return = 1'b0;

    // Reset held two cycles (requests during reset must not be granted), then idle.
    cyc(0, 5'b00000, 5'b00000, A, 0,  0, 0, 0, 0, 0, 0);
    cyc(0, 5'b11111, 5'b11111, A, 0,  0, 0, 0, 4, 0, 1);
    cyc(1, 5'b00000, 5'b00000, A, 0,  0, 0, 0, 4, 0, 1);

    // Fairness: single-flit packets everywhere incl. input 1; credits refilled.
    cyc(1, 5'b11111, 5'b11111, A, 1,  1, 0, 0, 4, 0, 1);
    cyc(1, 5'b11111, 5'b11111, A, 1,  1, 2, 0, 4, 0, 1);
    cyc(1, 5'b11111, 5'b11111, A, 1,  1, 3, 0, 4, 0, 1);
    cyc(1, 5'b11111, 5'b11111, A, 1,  1, 4, 0, 4, 0, 1);
    cyc(1, 5'b11111, 5'b11111, A, 1,  1, 0, 0, 4, 0, 1);
    // Input 1 (U-turn) and input 3 addressed elsewhere: no grant.
    cyc(1, 5'b01010, 5'b01010, 5'b10111, 0,  0, 0, 0, 4, 0, 1);

    // Packet lock on input 2 with a bubble; input 3 requests throughout.
    cyc(1, 5'b01100, 5'b01000, A, 1,  1, 2, 0, 4, 0, 1);
    cyc(1, 5'b01100, 5'b01000, A, 1,  1, 2, 1, 4, 0, 1);
    cyc(1, 5'b01000, 5'b01000, A, 0,  0, 0, 1, 4, 0, 1);
    cyc(1, 5'b01100, 5'b01100, A, 1,  1, 2, 1, 4, 0, 1);
    // ptr = 3 after the tail: input 3 beats input 0.
    cyc(1, 5'b01001, 5'b01001, A, 1,  1, 3, 0, 4, 0, 1);

    // Credit exhaustion with inputs 0 and 4 requesting, no returns.
    cyc(1, 5'b10001, 5'b10001, A, 0,  1, 4, 0, 4, 0, 1);
    cyc(1, 5'b10001, 5'b10001, A, 0,  1, 0, 0, 3, 0, 1);
    cyc(1, 5'b10001, 5'b10001, A, 0,  1, 4, 0, 2, 0, 1);
    cyc(1, 5'b10001, 5'b10001, A, 0,  1, 0, 0, 1, 0, 1);
    cyc(1, 5'b10001, 5'b10001, A, 1,  0, 0, 0, 0, 0, 1);
    cyc(1, 5'b10001, 5'b10001, A, 0,  1, 4, 0, 1, 0, 1);
    cyc(1, 5'b10001, 5'b10001, A, 0,  0, 0, 0, 0, 0, 1);
    // Same-cycle grant and return keep the count at 1.
    cyc(1, 5'b10001, 5'b10001, A, 1,  0, 0, 0, 0, 0, 1);
    cyc(1, 5'b10001, 5'b10001, A, 1,  1, 0, 0, 1, 0, 1);
    cyc(1, 5'b10001, 5'b10001, A, 1,  1, 4, 0, 1, 0, 1);
    // Refill, then overflow at full count.
    cyc(1, 5'b00000, 5'b00000, A, 1,  0, 0, 0, 1, 0, 1);
    cyc(1, 5'b00000, 5'b00000, A, 1,  0, 0, 0, 2, 0, 1);
    cyc(1, 5'b00000, 5'b00000, A, 1,  0, 0, 0, 3, 0, 1);
    cyc(1, 5'b00000, 5'b00000, A, 1,  0, 0, 0, 4, 0, 1);
    cyc(1, 5'b00000, 5'b00000, A, 0,  0, 0, 0, 4, 1, 1);
    cyc(1, 5'b00000, 5'b00000, A, 0,  0, 0, 0, 4, 0, 1);

    // Mid-packet reset: move ptr to 3, lock on input 3, then reset.
    cyc(1, 5'b00100, 5'b00100, A, 0,  1, 2, 0, 4, 0, 1);
    cyc(1, 5'b01000, 5'b00000, A, 0,  1, 3, 0, 3, 0, 1);
    cyc(1, 5'b01000, 5'b00000, A, 0,  1, 3, 1, 2, 0, 1);
    cyc(0, 5'b11000, 5'b10000, A, 0,  0, 0, 0, 1, 0, 1);
    // IDLE with ptr = 0 and full credits: input 0 wins over 3 and 4.
    cyc(1, 5'b11001, 5'b11001, A, 0,  1, 0, 0, 4, 0, 1);
    cyc(1, 5'b00000, 5'b00000, A, 0,  0, 0, 0, 3, 0, 1);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rr_port_arbiter.md
# rr_port_arbiter

Parametrised round-robin arbiter for one router output port; the successor to the fixed-width, per-direction RR processors. It decodes each input's next-hop address against the owning port, grants one requester per cycle with a rotating pointer, and holds the grant for the whole packet (head to tail). It also tracks downstream buffer credits locally instead of taking a single credit bit. One instance sits in front of each output port's crossbar select.

## Interface
Parameters:
- NUM_IN, 5, number of input ports; index 0 = N, 1 = S, 2 = W, 3 = E, 4 = L.
- ADDR_W, 3, next-hop address width per input.
- PORT_ID, 1, index/address of the output port this instance owns. Input PORT_ID never requests it (no U-turn).
- CREDITS, 4, downstream buffer depth; credit counter reset value.
- IDX_W, $clog2(NUM_IN), grant index width.
- CNT_W, $clog2(CREDITS+1), credit counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid_i  in  NUM_IN  flit present at input i.
- req_addr_i  in  NUM_IN*ADDR_W  next-hop address; input i occupies bits [i*ADDR_W +: ADDR_W].
- req_tail_i  in  NUM_IN  flit at input i is a tail flit; a single-flit packet has tail = 1.
- credit_return_i  in  1  one-cycle pulse when downstream frees one buffer slot.
- grant_o  out  NUM_IN  one-hot grant, combinational. A grant means the flit transfers this cycle.
- grant_idx_o  out  IDX_W  index of the granted input, for the crossbar select; 0 when there is no grant.
- grant_valid_o  out  1  OR of grant_o.
- credit_cnt_o  out  CNT_W  current credit count.
- locked_o  out  1  arbiter is in state LOCKED.
- credit_ovf_o  out  1  one-cycle pulse when a credit return arrives with the counter already at CREDITS.

## Operation
- Request qualification: req[i] = req_valid_i[i] & (addr slice i == PORT_ID) & (i != PORT_ID).
- Send enable: can_send = (credit_cnt != 0).
- State machine, with registers ptr (IDX_W), owner (IDX_W), state ∈ {IDLE, LOCKED}:
  - IDLE, with any req and can_send:
    - Grant the first requesting index found by scanning ptr, ptr+1, … modulo NUM_IN.
    - If the granted flit has tail = 1: stay IDLE and set ptr ← (granted + 1) mod NUM_IN.
    - If tail = 0: go to LOCKED and set owner ← granted.
  - IDLE, with no req or no credit: no grant; state and ptr unchanged.
  - LOCKED:
    - Grant only owner, and only when req[owner] & can_send. Other requesters are ignored.
    - A granted tail flit returns the arbiter to IDLE and sets ptr ← (owner + 1) mod NUM_IN.
    - A granted non-tail flit keeps the arbiter LOCKED.
    - No grant (bubble or no credit) keeps the arbiter LOCKED.
- Credits: next = cnt − grant_valid + credit_return.
  - Grant and return in the same cycle leave the count unchanged.
  - A return with cnt == CREDITS and no simultaneous grant saturates at CREDITS and pulses credit_ovf_o.
  - The count cannot underflow, because a grant requires cnt ≠ 0.
- Modulo wrap: ptr and owner wrap from NUM_IN−1 to 0. NUM_IN need not be a power of two.

## Timing
- Grant latency is 0 cycles: grant_o is combinational from registered state and the current inputs.
- State, ptr, owner and credit count update on the rising edge of clk.
- Reset values (reset low at an edge): state = IDLE, ptr = 0, owner = 0, credit_cnt = CREDITS, credit_ovf_o = 0.
- While reset is low: grant_o = 0, grant_idx_o = 0, grant_valid_o = 0, locked_o = 0. All combinational outputs are forced low.
- Reset asserted mid-packet abandons the lock. The arbiter is IDLE on the next cycle; recovering the packet is the upstream's responsibility.
- Credit spacing:
  - A credit returned in cycle t is usable for a grant in cycle t+1.
  - A grant in cycle t reduces the credit seen in cycle t+1.
- grant_idx_o is stable whenever grant_valid_o = 1 within a cycle. Its value is don't-care-free: 0 when there is no grant.

## Test plan
- Reset then idle: hold reset low for 2 cycles, then release with no requests. Required: credit_cnt_o = 4, grant_o = 0, locked_o = 0, ptr = 0.
- Round-robin fairness (PORT_ID = 1): inputs 0, 2, 3 and 4 all send continuous single-flit packets addressed to 1, with credits refilled every cycle. Required: grants rotate 0 → 2 → 3 → 4 → 0. Input 1 is never granted, even when it presents address 1.
- Packet lock: input 2 sends head, body, tail over 3 cycles while input 3 requests continuously. Required:
  - grant_idx_o = 2 for 3 cycles and locked_o = 1 after the head.
  - Then input 3 is granted and ptr = 3.
- Bubble and stall inside a packet: the owner deasserts valid for 1 cycle mid-packet. Required: no grant that cycle, locked_o stays 1, and the other requesters stay blocked.
- Credit exhaustion: CREDITS = 4, no returns, continuous requests. Required:
  - 4 grants, then credit_cnt_o = 0 and grant_valid_o = 0.
  - One credit_return_i pulse yields exactly one grant on the next cycle.
  - A same-cycle grant plus return keeps the count constant.
- Overflow and mid-packet reset:
  - A credit_return_i at count 4 gives credit_ovf_o = 1 for one cycle and the count stays 4.
  - Reset asserted while LOCKED gives IDLE, ptr = 0 and count = 4 on the next cycle.
